dkong_wav_player: RTL and testbench
===================================

# dkong_wav_player

Parametrised multi-channel PCM sample player for the Donkey Kong sound board. It takes NUM_CH active-low trigger lines and arbitrates between them by priority. For the winning channel it walks a per-channel region of sample ROM at the sample rate, using a request/valid ROM handshake, and presents the fetched 8-bit sample on a registered output. It sits between the sound CPU latch outputs and the audio mixer, and shares the sample ROM with other readers through the handshake.

## Interface
Parameters:
- NUM_CH, 4: number of trigger channels; channel index is the priority, highest index wins.
- SAMPLE_DIV, 2228: I_CLK cycles per sample tick.
- ADDR_W, 19: ROM address width.
- CNT_W, 13: sample counter width; maximum length is 2^CNT_W-1.
- ROM_BASE, 19'h20000: base added to every address.
- START_TABLE, NUM_CH*16 bits: per-channel 16-bit start offset; channel i occupies bits [16i+15:16i].
- LEN_TABLE, NUM_CH*CNT_W bits: per-channel last index, inclusive.
- LOOP_MASK, NUM_CH bits, 0: bit i set means channel i loops instead of stopping.

Ports:
- I_CLK  in  1  clock.
- I_RSTn  in  1  reset; asynchronous, active-low.
- I_SW  in  NUM_CH  triggers, active-low, asynchronous to I_CLK.
- O_ROM_AB  out  ADDR_W  ROM address; stable from O_ROM_RD until I_ROM_VLD.
- O_ROM_RD  out  1  one-cycle read request.
- I_ROM_DB  in  8  ROM data; sampled when I_ROM_VLD is high.
- I_ROM_VLD  in  1  data-valid, one cycle, arriving at least 1 cycle after O_ROM_RD.
- O_WAV  out  8  unsigned sample; idle level 8'h80.
- O_BUSY  out  1  a channel is active.
- O_CH  out  max(1,$clog2(NUM_CH))  active channel index.
- O_UNDERRUN  out  1  sticky; set when a tick arrives while a fetch is outstanding.

## Operation
- Trigger path: each I_SW bit passes through a 2-FF synchroniser, is inverted, and is rising-edge detected, giving trig[i]. A trigger therefore takes effect 3 cycles after I_SW falls.
- Arbitration: take w, the highest set trig[i]. The channel restarts when idle, or when w >= the active channel (same channel retriggers). A lower-priority trigger while busy is dropped, not queued.
- Restart: ch <= w, cnt <= 0, O_BUSY <= 1. O_WAV holds its last value until the first new sample arrives.
- States: IDLE, PLAY, FETCH, DRAIN.
  - IDLE: on an accepted trigger, go to PLAY.
  - PLAY, on a tick with cnt <= LEN[ch]: O_ROM_AB <= ROM_BASE + START[ch] + cnt, truncated to ADDR_W; pulse O_ROM_RD; go to FETCH.
  - PLAY, on a tick with cnt > LEN[ch]: if LOOP_MASK[ch], set cnt <= 0 and issue the fetch for index 0 on the same tick. Otherwise go to IDLE, O_BUSY <= 0, O_WAV <= 8'h80.
  - FETCH: on I_ROM_VLD, O_WAV <= I_ROM_DB, cnt <= cnt+1, go to PLAY. A tick in FETCH sets O_UNDERRUN; that tick is lost.
  - Restart accepted in FETCH: go to DRAIN. DRAIN waits for I_ROM_VLD, discards the data, and then goes to PLAY with the new channel.
  - Restart accepted in PLAY or IDLE: go to PLAY.
- Simultaneous events:
  - An accepted trigger has precedence over end-of-sample and over a tick in the same cycle; that tick does not fetch.
  - I_ROM_VLD and an accepted trigger in the same FETCH cycle: the data is discarded, the new channel is loaded, and the state goes to PLAY.
- Tick generator: free-running, never restarted by triggers. The tick asserts for 1 cycle when the divider equals SAMPLE_DIV-1.

## Timing
- Reset values:
  - O_ROM_AB = 0, O_ROM_RD = 0, O_WAV = 8'h80, O_BUSY = 0, O_CH = 0, O_UNDERRUN = 0.
  - State IDLE, divider 0, synchronisers all 0, which means all triggers are released.
- Reset mid-fetch: all state is cleared. A late I_ROM_VLD after reset is ignored in IDLE.
- All outputs are registered.
- O_ROM_RD rises in the cycle after the tick; O_ROM_AB is valid in the same cycle.
- O_WAV updates in the cycle after I_ROM_VLD.
- The first sample of a channel is fetched on the first tick at least 1 cycle after the restart.
- A non-looping channel produces exactly LEN+1 samples. O_BUSY falls on the tick following the last sample.

## Structure
- Package dkong_wav_pkg holds:
  - the state encoding (2-bit localparams),
  - IDLE_LEVEL = 8'h80,
  - the default START_TABLE and LEN_TABLE for the board: walk 16'h0000/7d0, jump 16'h1000/1e20, foot 16'h3000/1750, roar slot 16'h5000/0fff.
- Sub-module dkong_wav_trig contains the synchroniser, edge detect and priority encoder. Its outputs are trig_any, trig_idx, and the registered active channel.

## Test plan
1. Reset, then hold I_SW = all 1s for 10 ticks. Required: O_ROM_RD never pulses, O_WAV = 8'h80, O_BUSY = 0.
2. Pulse I_SW[0] low with LEN = 3 and a ROM model with VLD latency 2. Required: exactly 4 reads at ROM_BASE+0 through ROM_BASE+3, O_WAV follows the ROM bytes, then returns to 8'h80 and O_BUSY falls on the 5th tick.
3. While channel 2 is active, pulse I_SW[1]. Required: ignored, addresses continue. Then pulse I_SW[3]. Required: O_CH = 3, the next read is at START[3].
4. Assert an accepted trigger while a fetch is outstanding (VLD latency 50). Required: the stale byte is not written to O_WAV, and the next read is index 0 of the new channel.
5. With LOOP_MASK[1] = 1 and LEN = 2, run 7 ticks. Required: address indices 0,1,2,0,1,2,0 and O_BUSY stays 1.
6. Set VLD latency > SAMPLE_DIV. Required: O_UNDERRUN is set and remains set until reset; assert reset mid-fetch and check all reset values.

Source files
------------

// File: rtl/dkong_wav_pkg.sv
// Shared definitions for the Donkey Kong PCM sample player: FSM encoding,
// idle output level and the board's default sample tables.
package dkong_wav_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] IDLE_LEVEL = 8'h80;

  // walk, jump, foot, roar slot (channel 0 in the low bits)
  localparam logic [63:0] DEF_START_TABLE = {16'h5000, 16'h3000, 16'h1000, 16'h0000};
  localparam logic [51:0] DEF_LEN_TABLE   = {13'h0fff, 13'h1750, 13'h1e20, 13'h07d0};

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dkong_wav_trig.sv
// Trigger front end: synchronise active-low switches, detect presses,
// pick the highest pressed channel and hold the active channel index.
module dkong_wav_trig
  import dkong_wav_pkg::*;
#(
  parameter int NUM_CH = 4
)(
  input  logic                      I_CLK,
  input  logic                      I_RSTn,
  input  logic [NUM_CH-1:0]         sw,
  input  logic                      load,
  output logic                      trig_any,
  output logic [ch_w(NUM_CH)-1:0]   trig_idx,
  output logic [ch_w(NUM_CH)-1:0]   ch
);
  localparam int CH_W = ch_w(NUM_CH);

  // Stored inverted so that the all-zero reset state means "released".
  logic [NUM_CH-1:0] sync1, sync2, prev, trig;

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      ch    <= '0;
    end else begin
      sync1 <= ~sw;
      sync2 <= sync1;
      prev  <= sync2;
      if (load) ch <= trig_idx;
    end
  end

  assign trig     = sync2 & ~prev;
  assign trig_any = |trig;

  always_comb begin
    trig_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (trig[i]) trig_idx = CH_W'(i);
  end

endmodule

// File: rtl/dkong_wav_player.sv
// Multi-channel PCM sample player: priority triggers, sample-rate ROM walk
// over a request/valid handshake, registered 8-bit sample output.
module dkong_wav_player
  import dkong_wav_pkg::*;
#(
  parameter int                      NUM_CH      = 4,
  parameter int                      SAMPLE_DIV  = 2228,
  parameter int                      ADDR_W      = 19,
  parameter int                      CNT_W       = 13,
  parameter logic [ADDR_W-1:0]       ROM_BASE    = ADDR_W'(19'h20000),
  parameter logic [NUM_CH*16-1:0]    START_TABLE = (NUM_CH*16)'(DEF_START_TABLE),
  parameter logic [NUM_CH*CNT_W-1:0] LEN_TABLE   = (NUM_CH*CNT_W)'(DEF_LEN_TABLE),
  parameter logic [NUM_CH-1:0]       LOOP_MASK   = '0
)(
  input  logic                     I_CLK,
  input  logic                     I_RSTn,
  input  logic [NUM_CH-1:0]        I_SW,
  output logic [ADDR_W-1:0]        O_ROM_AB,
  output logic                     O_ROM_RD,
  input  logic [7:0]               I_ROM_DB,
  input  logic                     I_ROM_VLD,
  output logic [7:0]               O_WAV,
  output logic                     O_BUSY,
  output logic [ch_w(NUM_CH)-1:0]  O_CH,
  output logic                     O_UNDERRUN
);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CH_W  = ch_w(NUM_CH);

  // Sample-rate divider; free-running, triggers never restart it.
  logic [DIV_W-1:0] div;
  logic             tick;

  assign tick = (div == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) div <= '0;
    else         div <= tick ? '0 : div + 1'b1;
  end

  logic            trig_any, accept;
  logic [CH_W-1:0] trig_idx;

  dkong_wav_trig #(.NUM_CH(NUM_CH)) u_trig (
    .I_CLK    (I_CLK),
    .I_RSTn   (I_RSTn),
    .sw       (I_SW),
    .load     (accept),
    .trig_any (trig_any),
    .trig_idx (trig_idx),
    .ch       (O_CH)
  );

  // Equal priority retriggers; lower priority while busy is dropped.
  assign accept = trig_any && (!O_BUSY || trig_idx >= O_CH);

  // One extra counter bit so cnt can reach LEN+1 even at the maximum length.
  logic [CNT_W:0]    cnt, cnt_n;
  logic [CNT_W-1:0]  len_cur;
  logic [15:0]       start_cur;
  logic              loop_cur;
  logic [ADDR_W-1:0] base_addr;

  assign len_cur   = LEN_TABLE[CNT_W * int'(O_CH) +: CNT_W];
  assign start_cur = START_TABLE[16 * int'(O_CH) +: 16];
  assign loop_cur  = LOOP_MASK[O_CH];
  assign base_addr = ROM_BASE + ADDR_W'(start_cur);

  state_t            state, state_n;
  logic [ADDR_W-1:0] ab_n;
  logic              rd_n, busy_n, und_n;
  logic [7:0]        wav_n;

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      O_ROM_AB   <= '0;
      O_ROM_RD   <= 1'b0;
      O_WAV      <= IDLE_LEVEL;
      O_BUSY     <= 1'b0;
      O_UNDERRUN <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      O_ROM_AB   <= ab_n;
      O_ROM_RD   <= rd_n;
      O_WAV      <= wav_n;
      O_BUSY     <= busy_n;
      O_UNDERRUN <= und_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ab_n    = O_ROM_AB;
    rd_n    = 1'b0;
    wav_n   = O_WAV;
    busy_n  = O_BUSY;
    und_n   = O_UNDERRUN | (tick && (state == ST_FETCH || state == ST_DRAIN));

    case (state)
      ST_IDLE: if (accept) state_n = ST_PLAY;
      ST_PLAY: begin
        // a trigger in this cycle wins over the tick
        if (!accept && tick) begin
          if (cnt <= {1'b0, len_cur}) begin
            ab_n    = base_addr + ADDR_W'(cnt);
            rd_n    = 1'b1;
            state_n = ST_FETCH;
          end else if (loop_cur) begin
            cnt_n   = '0;
            ab_n    = base_addr;
            rd_n    = 1'b1;
            state_n = ST_FETCH;
          end else begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
            wav_n   = IDLE_LEVEL;
          end
        end
      end
      ST_FETCH: begin
        if (accept) begin
          state_n = I_ROM_VLD ? ST_PLAY : ST_DRAIN;
        end else if (I_ROM_VLD) begin
          wav_n   = I_ROM_DB;
          cnt_n   = cnt + 1'b1;
          state_n = ST_PLAY;
        end
      end
      ST_DRAIN: if (I_ROM_VLD) state_n = ST_PLAY;
      default:  state_n = ST_IDLE;
    endcase

    if (accept) begin
      cnt_n  = '0;
      busy_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_dkong_wav_player.sv
// Directed bench for dkong_wav_player: table of single-trigger runs plus
// hand sequences for priority, restart mid-fetch, underrun and reset.
module tb_dkong_wav_player;
  localparam int DIV  = 64;
  localparam int BASE = 'h20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sw = 4'hF;
  logic [18:0] rom_ab;
  logic        rom_rd;
  logic [7:0]  rom_db = 8'h00;
  logic        rom_vld = 1'b0;
  logic [7:0]  wav;
  logic        busy;
  logic [1:0]  ch;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  int start_tb[4] = '{'h000, 'h100, 'h200, 'h300};
  int len_tb[4]   = '{3, 2, 9, 5};
  int loop_tb[4]  = '{0, 1, 0, 0};

  dkong_wav_player #(
    .NUM_CH(4), .SAMPLE_DIV(DIV), .ADDR_W(19), .CNT_W(13),
    .ROM_BASE(19'h20000),
    .START_TABLE({16'h0300, 16'h0200, 16'h0100, 16'h0000}),
    .LEN_TABLE({13'd5, 13'd9, 13'd2, 13'd3}),
    .LOOP_MASK(4'b0010)
  ) dut (
    .I_CLK(clk), .I_RSTn(rst_n), .I_SW(sw),
    .O_ROM_AB(rom_ab), .O_ROM_RD(rom_rd), .I_ROM_DB(rom_db), .I_ROM_VLD(rom_vld),
    .O_WAV(wav), .O_BUSY(busy), .O_CH(ch), .O_UNDERRUN(underrun)
  );

  always #5 clk = ~clk;

  // reference phase of the sample divider, used only to place stimulus
  int tb_div;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_div <= 0;
    else        tb_div <= (tb_div == DIV - 1) ? 0 : tb_div + 1;

  function automatic logic [7:0] rom_byte(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [18:0] exp_addr(input int c, input int idx);
    return 19'(BASE + start_tb[c] + idx);
  endfunction

  // ROM responder: VLD arrives lat cycles after the cycle with O_ROM_RD high
  int          lat = 2;
  int          left = 0;
  logic        pend = 1'b0;
  logic [18:0] pa = '0;
  always @(negedge clk) begin
    rom_vld = 1'b0;
    if (pend) begin
      if (left == 0) begin
        rom_vld = 1'b1;
        rom_db  = rom_byte(pa);
        pend    = 1'b0;
      end else left = left - 1;
    end
    if (rom_rd === 1'b1) begin
      pend = 1'b1;
      left = lat - 1;
      pa   = rom_ab;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for event", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sw = 4'hF;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic align(input int ph);
    for (int i = 0; i <= DIV; i++) begin
      if (tb_div == ph) return;
      step();
    end
    fail("align");
  endtask

  task automatic pulse(input logic [3:0] v);
    sw = v;
    repeat (4) step();
    sw = 4'hF;
  endtask

  task automatic next_rd(input string nm, output logic [18:0] a);
    a = '0;
    for (int i = 0; i < 3 * DIV; i++) begin
      step();
      if (rom_rd) begin
        a = rom_ab;
        return;
      end
    end
    fail(nm);
  endtask

  typedef struct {
    logic [3:0] sw_n;
    int         ch;
    int         ticks;
    int         reads;
    logic       busy;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int n, input vec_t v);
    int         k;
    int         idx;
    logic       wav_due;
    logic [7:0] wav_exp;
    do_reset();
    lat = 2;
    align(2);
    sw = v.sw_n;
    k = 0;
    wav_due = 1'b0;
    wav_exp = 8'h00;
    for (int c = 0; c < v.ticks * DIV + 8; c++) begin
      step();
      if (c == 3) sw = 4'hF;
      if (wav_due) chk($sformatf("v%0d wav", n), 32'(wav), 32'(wav_exp));
      wav_due = rom_vld;
      wav_exp = rom_db;
      if (rom_rd) begin
        idx = (loop_tb[v.ch] != 0) ? k % (len_tb[v.ch] + 1) : k;
        chk($sformatf("v%0d addr%0d", n, k), 32'(rom_ab), 32'(exp_addr(v.ch, idx)));
        k++;
      end
    end
    chk($sformatf("v%0d reads", n), 32'(k), 32'(v.reads));
    chk($sformatf("v%0d busy", n), 32'(busy), 32'(v.busy));
    chk($sformatf("v%0d ch", n), 32'(ch), 32'(v.ch));
    chk($sformatf("v%0d underrun", n), 32'(underrun), 32'd0);
    if (!v.busy) chk($sformatf("v%0d idle wav", n), 32'(wav), 32'h80);
  endtask

  initial begin
    logic [18:0] a;
    int          nrd;

    vecs[0] = '{4'hF, 0, 10, 0, 1'b0};  // no trigger
    vecs[1] = '{4'hE, 0,  4, 4, 1'b1};  // ch0, still busy after 4 ticks
    vecs[2] = '{4'hE, 0,  5, 4, 1'b0};  // ch0 ends on the 5th tick
    vecs[3] = '{4'hD, 1,  7, 7, 1'b1};  // looping ch1
    vecs[4] = '{4'hA, 2,  4, 4, 1'b1};  // ch0+ch2 together, ch2 wins
    vecs[5] = '{4'h7, 3,  8, 6, 1'b0};  // ch3 plays to the end

    repeat (2) step();
    chk("reset ab", 32'(rom_ab), 32'd0);
    chk("reset rd", 32'(rom_rd), 32'd0);
    chk("reset wav", 32'(wav), 32'h80);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ch", 32'(ch), 32'd0);
    chk("reset underrun", 32'(underrun), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // lower priority ignored, higher priority restarts; the restart lands on
    // the same cycle as the outstanding VLD, so that byte must be dropped
    do_reset();
    lat = 2;
    align(2);
    pulse(4'hB);
    for (int i = 0; i < 3; i++) begin
      next_rd("prio rd", a);
      chk($sformatf("prio ch2 addr%0d", i), 32'(a), 32'(exp_addr(2, i)));
    end
    pulse(4'hD);
    next_rd("prio rd", a);
    chk("prio low ignored addr", 32'(a), 32'(exp_addr(2, 3)));
    chk("prio low ignored ch", 32'(ch), 32'd2);
    pulse(4'h7);
    chk("prio high ch", 32'(ch), 32'd3);
    step();
    chk("prio busy", 32'(busy), 32'd1);
    chk("prio dropped byte", 32'(wav), 32'(rom_byte(exp_addr(2, 2))));
    next_rd("prio rd", a);
    chk("prio high addr", 32'(a), 32'(exp_addr(3, 0)));

    // restart while a slow fetch is outstanding
    do_reset();
    lat = 50;
    align(2);
    pulse(4'hE);
    next_rd("drain rd", a);
    chk("drain first addr", 32'(a), 32'(exp_addr(0, 0)));
    repeat (5) step();
    pulse(4'h7);
    repeat (45) step();
    chk("drain stale wav", 32'(wav), 32'h80);
    chk("drain ch", 32'(ch), 32'd3);
    next_rd("drain rd", a);
    chk("drain new addr", 32'(a), 32'(exp_addr(3, 0)));
    repeat (52) step();
    chk("drain new wav", 32'(wav), 32'(rom_byte(exp_addr(3, 0))));
    chk("drain underrun", 32'(underrun), 32'd0);

    // underrun, sticky, then reset in the middle of a fetch
    do_reset();
    lat = 80;
    align(2);
    pulse(4'h7);
    next_rd("under rd", a);
    chk("under addr", 32'(a), 32'(exp_addr(3, 0)));
    chk("under before", 32'(underrun), 32'd0);
    repeat (DIV + 2) step();
    chk("under set", 32'(underrun), 32'd1);
    repeat (100) step();
    chk("under sticky", 32'(underrun), 32'd1);
    chk("under wav", 32'(wav), 32'(rom_byte(exp_addr(3, 0))));
    rst_n = 1'b0;
    #2;
    chk("midreset ab", 32'(rom_ab), 32'd0);
    chk("midreset rd", 32'(rom_rd), 32'd0);
    chk("midreset wav", 32'(wav), 32'h80);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset ch", 32'(ch), 32'd0);
    chk("midreset underrun", 32'(underrun), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    nrd = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rom_rd) nrd++;
    end
    chk("late vld reads", 32'(nrd), 32'd0);
    chk("late vld wav", 32'(wav), 32'h80);
    chk("late vld busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
